// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell and a carry flip-flop, LSB first.
// A start/busy/done handshake frames each WIDTH-cycle addition.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // One extra bit so WIDTH=1 and powers of two still fit the last index.
    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic s_bit;
    logic carry_next;

    assign s_bit      = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_next = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) |
                        (b_sr_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    count_d = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    state_d = StShift;
                end
            end
            StShift: begin
                carry_d = carry_next;
                // New bit enters at the MSB; shift form stays legal for WIDTH=1.
                sum_d   = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                count_d = count_q + CW'(1);
                if (count_q == LastBit) begin
                    cout_d  = carry_next;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    // Stimulus only: starts one WIDTH=8 op and reports what was seen at done.
    task automatic run_op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                           output logic [7:0] rs, output logic rc, output int lat,
                           output logic busy0);
        @(negedge clk);
        a8 = ta; b8 = tb_v; cin8 = tc; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        busy0 = busy8;
        lat = -1; rs = sum8; rc = cout8;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done8) begin
                lat = k; rs = sum8; rc = cout8;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start8 = 1'b1; start1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            errors++;
            $display("FAIL reset8: got %b expected 0", {busy8, done8, sum8, cout8});
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'h0) begin
            errors++;
            $display("FAIL reset1: got %b expected 0", {busy1, done1, sum1, cout1});
        end
        start8 = 1'b0; start1 = 1'b0; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b expected 0", busy8);
        end
    endtask

    task automatic test_basic;
        logic [7:0] rs; logic rc, b0; int lat;
        run_op8(8'h3C, 8'h5A, 1'b0, rs, rc, lat, b0);
        checks++;
        if (b0 !== 1'b1) begin
            errors++; $display("FAIL basic_busy: got %b expected 1", b0);
        end
        checks++;
        if (lat != 8) begin
            errors++; $display("FAIL basic_latency: got %0d expected 8", lat);
        end
        checks++;
        if ({rc, rs} !== 9'h096) begin
            errors++; $display("FAIL basic_sum: got %h expected 096", {rc, rs});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy8, done8, cout8, sum8} !== {3'b000, 8'h96}) begin
                errors++;
                $display("FAIL basic_hold: got %b expected 000_10010110",
                         {busy8, done8, cout8, sum8});
            end
        end
    endtask

    task automatic test_carry;
        logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [8:0] ve [3] = '{9'h100, 9'h1FF, 9'h001};
        logic [7:0] rs; logic rc, b0; int lat;
        for (int i = 0; i < 3; i++) begin
            run_op8(va[i], vb[i], vc[i], rs, rc, lat, b0);
            checks++;
            if ({rc, rs} !== ve[i] || lat != 8) begin
                errors++;
                $display("FAIL carry[%0d]: got %h lat %0d expected %h lat 8",
                         i, {rc, rs}, lat, ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int k1 = -1, k2 = -1;
        logic busy9 = 1'b1, busy10 = 1'b0;
        logic [8:0] r1 = '0, r2 = '0;
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        for (int k = 0; k <= 30; k++) begin
            @(negedge clk);
            if (k == 3) begin
                a8 = 8'h01; b8 = 8'h01;
            end
            if (k == 9) busy9 = busy8;
            if (k == 10) busy10 = busy8;
            if (done8 && k1 < 0) begin
                k1 = k; r1 = {cout8, sum8};
            end else if (done8 && k2 < 0) begin
                k2 = k; r2 = {cout8, sum8};
                start8 = 1'b0;
                break;
            end
        end
        start8 = 1'b0;
        checks++;
        if (k1 != 8 || r1 !== 9'h030) begin
            errors++;
            $display("FAIL b2b_first: got %h at %0d expected 030 at 8", r1, k1);
        end
        checks++;
        if (busy9 !== 1'b0 || busy10 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: busy got %b%b expected 01", busy9, busy10);
        end
        checks++;
        if (k2 != 18 || r2 !== 9'h002) begin
            errors++;
            $display("FAIL b2b_second: got %h at %0d expected 002 at 18", r2, k2);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy8 !== 1'b0) begin
            errors++; $display("FAIL b2b_idle: busy got %b expected 0", busy8);
        end
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        logic [7:0] rs; logic rc, b0; int lat;
        @(negedge clk);
        a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy8, done8, sum8, cout8} !== 11'h0) begin
            errors++;
            $display("FAIL abort_clear: got %b expected 0", {busy8, done8, sum8, cout8});
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen);
        end
        run_op8(8'h7F, 8'h01, 1'b0, rs, rc, lat, b0);
        checks++;
        if ({rc, rs} !== 9'h080 || lat != 8) begin
            errors++;
            $display("FAIL abort_restart: got %h lat %0d expected 080 lat 8", {rc, rs}, lat);
        end
    endtask

    task automatic test_width1;
        logic [1:0] exp_fa [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        logic [2:0] v;
        logic d0;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            @(negedge clk);
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            d0 = done1;
            @(negedge clk);
            checks++;
            if (d0 !== 1'b0 || done1 !== 1'b1 || {cout1, sum1} !== exp_fa[i]) begin
                errors++;
                $display("FAIL w1[%0d]: done %b%b cs %b expected done 01 cs %b",
                         i, d0, done1, {cout1, sum1}, exp_fa[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [7:0] ra, rb, rs; logic rcin, rc, b0; int lat;
        logic [8:0] expv;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            expv = {1'b0, ra} + {1'b0, rb} + {8'h00, rcin};
            run_op8(ra, rb, rcin, rs, rc, lat, b0);
            checks++;
            if ({rc, rs} !== expv || lat != 8) begin
                errors++;
                $display("FAIL rand[%0d]: %h+%h+%b got %h lat %0d expected %h lat 8",
                         i, ra, rb, rcin, {rc, rs}, lat, expv);
            end
            @(negedge clk);
            checks++;
            if (done8 !== 1'b0) begin
                errors++; $display("FAIL rand_done_width[%0d]: got %b expected 0", i, done8);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid();
        test_width1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
